// File: rtl/sa_cache_mem_ctrl.sv
// rtl/sa_cache_mem_ctrl.sv - miss/writeback controller between sa_cache and main memory
module sa_cache_mem_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_miss_valid,
    output logic                         o_miss_ready,
    input  logic [ADDR_W-1:0]            i_miss_addr,
    input  logic                         i_victim_dirty,
    input  logic [ADDR_W-1:0]            i_victim_addr,
    input  logic [LINE_WORDS*WORD_W-1:0] i_victim_line,
    output logic                         o_fill_valid,
    output logic [ADDR_W-1:0]            o_fill_addr,
    output logic [LINE_WORDS*WORD_W-1:0] o_fill_line,
    output logic                         o_fill_err,
    output logic                         o_mem_req,
    output logic                         o_mem_we,
    output logic [ADDR_W-1:0]            o_mem_addr,
    output logic [WORD_W-1:0]            o_mem_wdata,
    input  logic                         i_mem_ack,
    input  logic [WORD_W-1:0]            i_mem_rdata
);

    localparam int KW    = $clog2(LINE_WORDS);
    localparam int OFF_W = $clog2(LINE_WORDS * WORD_W / 8);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF_W;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_RF, S_DONE} state_t;

    state_t                                 state_q, state_d;
    logic [ADDR_W-1:0]                      miss_base_q, miss_base_d;
    logic [ADDR_W-1:0]                      victim_base_q, victim_base_d;
    logic [LINE_WORDS-1:0][WORD_W-1:0]      line_q, line_d;
    logic [KW-1:0]                          k_q, k_d;
    logic [TW-1:0]                          tcnt_q, tcnt_d;
    logic [ADDR_W-1:0]                      fill_addr_q, fill_addr_d;
    logic [LINE_WORDS-1:0][WORD_W-1:0]      fill_line_q, fill_line_d;
    logic                                   fill_err_q, fill_err_d;

    logic busy;
    logic beat_ack;
    logic last_beat;
    logic timed_out;

    always_comb begin
        busy      = (state_q == S_WB) || (state_q == S_RF);
        beat_ack  = busy && i_mem_ack;
        last_beat = (k_q == KW'(LINE_WORDS - 1));
        // The stall that would make the wait reach TIMEOUT aborts the beat.
        timed_out = busy && !i_mem_ack && (tcnt_q == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            miss_base_q   <= '0;
            victim_base_q <= '0;
            line_q        <= '0;
            k_q           <= '0;
            tcnt_q        <= '0;
            fill_addr_q   <= '0;
            fill_line_q   <= '0;
            fill_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            miss_base_q   <= miss_base_d;
            victim_base_q <= victim_base_d;
            line_q        <= line_d;
            k_q           <= k_d;
            tcnt_q        <= tcnt_d;
            fill_addr_q   <= fill_addr_d;
            fill_line_q   <= fill_line_d;
            fill_err_q    <= fill_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (i_miss_valid) state_d = i_victim_dirty ? S_WB : S_RF;
            S_WB: begin
                if (timed_out)                  state_d = S_DONE;
                else if (beat_ack && last_beat) state_d = S_RF;
            end
            S_RF: if (timed_out || (beat_ack && last_beat)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        miss_base_d   = miss_base_q;
        victim_base_d = victim_base_q;
        line_d        = line_q;
        k_d           = k_q;
        tcnt_d        = tcnt_q;
        fill_addr_d   = fill_addr_q;
        fill_line_d   = fill_line_q;
        fill_err_d    = fill_err_q;

        if (state_q == S_IDLE && i_miss_valid) begin
            miss_base_d   = i_miss_addr & BASE_MASK;
            victim_base_d = i_victim_addr & BASE_MASK;
            line_d        = i_victim_line;
        end

        if (busy) begin
            if (i_mem_ack) begin
                tcnt_d = '0;
                k_d    = k_q + KW'(1);
                if (state_q == S_RF) line_d[k_q] = i_mem_rdata;
            end else if (tcnt_q != TW'(TIMEOUT)) begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end

        if (state_d != state_q) begin
            tcnt_d = '0;
            k_d    = '0;
        end

        // Fill outputs are captured on DONE entry and held until the next fill.
        if (state_d == S_DONE && state_q != S_DONE) begin
            fill_addr_d = miss_base_q;
            fill_err_d  = timed_out;
            fill_line_d = timed_out ? '0 : line_d;
        end
    end

    always_comb begin
        o_miss_ready = (state_q == S_IDLE);
        o_fill_valid = (state_q == S_DONE);
        o_fill_addr  = fill_addr_q;
        o_fill_line  = fill_line_q;
        o_fill_err   = fill_err_q;
        o_mem_req    = busy;
        o_mem_we     = (state_q == S_WB);
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        if (busy) begin
            o_mem_addr = ((state_q == S_WB) ? victim_base_q : miss_base_q)
                       + ADDR_W'(k_q) * ADDR_W'(WORD_W / 8);
        end
        if (state_q == S_WB) o_mem_wdata = line_q[k_q];
    end

endmodule
